bram_reverse_core: RTL and testbench
====================================

BRAM_REVERSE_CORE -- requirements
Module: bram_reverse_core

Interface
REQ-001 SHALL have parameter DEPTH, default 2048: words per region (power of two, >=4).
REQ-002 SHALL have parameter WIDTH, default 32: data word width.
REQ-003 SHALL have parameter RD_LAT, default 1: source BRAM read latency in cycles (1 or 2).
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: level request from the control register.
REQ-007 SHALL have port done, output, 1: copy finished; held until start drops.
REQ-008 SHALL have port busy, output, 1: high in RUN and DRAIN.
REQ-009 SHALL have port src_addr, output, log2(DEPTH): source BRAM word address.
REQ-010 SHALL have port src_en, output, 1: source read enable.
REQ-011 SHALL have port src_dout, input, WIDTH: source read data, valid RD_LAT cycles after src_en.
REQ-012 SHALL have port dst_addr, output, log2(DEPTH): destination BRAM word address.
REQ-013 SHALL have port dst_din, output, WIDTH: destination write data.
REQ-014 SHALL have port dst_we, output, 1: destination write enable (en tied to we).

Function
REQ-015 SHALL use FSM states IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE: start=1 sampled -> RUN, read counter=0; start=0 -> stay.
REQ-017 RUN: src_en=1, src_addr=counter each cycle; counter increments; after issuing address DEPTH-1 -> DRAIN.
REQ-018 Reads SHALL be fully pipelined: one read per cycle, no bubbles, DEPTH consecutive src_en cycles.
REQ-019 A valid shift register of length RD_LAT SHALL track in-flight reads; when its output is 1, dst_we=1, dst_din=src_dout, dst_addr=DEPTH-1-k for the k-th returned word.
REQ-020 DRAIN: src_en=0; when the last write (dst_addr=0) issues -> DONE.
REQ-021 With start sampled at edge 0: reads at cycles 1..DEPTH, last write at cycle DEPTH+RD_LAT, done=1 from cycle DEPTH+RD_LAT+1.
REQ-022 DONE: done=1; start=0 sampled -> IDLE, done=0 next cycle.
REQ-023 start deasserted during RUN/DRAIN SHALL be ignored; the copy completes, DONE is entered, and done is high exactly one cycle.
REQ-024 start held high after return to IDLE SHALL NOT retrigger until it has been seen low in DONE.
REQ-025 Address counters SHALL be log2(DEPTH) bits; the final read address DEPTH-1 SHALL NOT wrap to 0 or issue an extra read.

Reset
REQ-026 reset SHALL force IDLE; done=0, busy=0, src_en=0, dst_we=0, src_addr=0, dst_addr=0, dst_din=0, valid pipeline cleared.
REQ-027 reset mid-RUN/DRAIN SHALL abort with no further dst_we; partial destination contents are undefined.

Configuration
REQ-028 With REV_CHECKSUM_EN defined: output checksum[WIDTH-1:0] SHALL hold the modulo-2^WIDTH sum of all written words, cleared on leaving IDLE, stable from done=1 until the next start.
REQ-029 Without REV_CHECKSUM_EN: no checksum port, no adder logic.

Structure
REQ-030 Package rev_pkg SHALL hold the state enum type and default DEPTH/WIDTH constants.
REQ-031 Sub-module rev_valid_pipe (RD_LAT-deep valid/data delay line) SHALL implement REQ-019.

Verification
REQ-032 Source[i]=i for i=0..2047, RD_LAT=1, pulse start -> destination[i]=2047-i for all i; done rises at cycle 2050.
REQ-033 RD_LAT=2, same data -> identical destination contents; done at cycle 2051; src_en high exactly 2048 cycles.
REQ-034 start held high through DONE, then dropped -> done stays 1 until start=0, then 0 next cycle; no second copy.
REQ-035 reset asserted at cycle 1000 of RUN -> all outputs at reset values next cycle; no dst_we thereafter; a fresh start completes correctly.
REQ-036 REV_CHECKSUM_EN, source[i]=i -> checksum=0x001FFC00 at done.

Source files
------------

// File: rtl/rev_pkg.sv
// rtl/rev_pkg.sv - shared types and default sizes for the BRAM reverse-copy core
package rev_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } rev_state_t;

  localparam int REV_DEPTH_DEF = 2048;
  localparam int REV_WIDTH_DEF = 32;

endpackage

// File: rtl/bram_reverse_core_if.sv
// rtl/bram_reverse_core_if.sv - source/destination BRAM port bundle for the reverse-copy core
interface bram_reverse_core_if
  import rev_pkg::*;
#(
  parameter int DEPTH = REV_DEPTH_DEF,
  parameter int WIDTH = REV_WIDTH_DEF
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    src_addr;
  logic             src_en;
  logic [WIDTH-1:0] src_dout;
  logic [AW-1:0]    dst_addr;
  logic [WIDTH-1:0] dst_din;
  logic             dst_we;

  // master is the copy engine, slave is the memory side
  modport master (
    output src_addr, src_en, dst_addr, dst_din, dst_we,
    input  src_dout
  );

  modport slave (
    input  src_addr, src_en, dst_addr, dst_din, dst_we,
    output src_dout
  );

endinterface

// File: rtl/rev_valid_pipe.sv
// rtl/rev_valid_pipe.sv - RD_LAT-deep valid delay line aligning issued reads with returned data
module rev_valid_pipe
  import rev_pkg::*;
#(
  parameter int WIDTH  = REV_WIDTH_DEF,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_issue,
  input  logic [WIDTH-1:0] rd_data,
  output logic             wr_valid,
  output logic [WIDTH-1:0] wr_data
);

  logic [RD_LAT-1:0] vld_sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= rd_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  // data is forced to zero outside a valid slot so idle outputs stay clean
  assign wr_valid = vld_sr[RD_LAT-1];
  assign wr_data  = wr_valid ? rd_data : '0;

endmodule

// File: rtl/bram_reverse_core.sv
// rtl/bram_reverse_core.sv - copies a BRAM region into another in reversed word order
// Optional running sum of written words enabled with REV_CHECKSUM_EN.
module bram_reverse_core
  import rev_pkg::*;
#(
  parameter int DEPTH  = REV_DEPTH_DEF,
  parameter int WIDTH  = REV_WIDTH_DEF,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             done,
  output logic             busy,
  bram_reverse_core_if.master mem
`ifdef REV_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0] checksum
`endif
);

  localparam int AW = $clog2(DEPTH);

  rev_state_t       state;
  logic [AW-1:0]    wr_cnt;
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             last_wr;

  rev_valid_pipe #(
    .WIDTH (WIDTH),
    .RD_LAT(RD_LAT)
  ) u_valid_pipe (
    .clk     (clk),
    .reset   (reset),
    .rd_issue(mem.src_en),
    .rd_data (mem.src_dout),
    .wr_valid(wr_valid),
    .wr_data (wr_data)
  );

  // DEPTH is a power of two, so DEPTH-1-k is simply the bitwise inverse of k
  assign last_wr      = wr_valid && (wr_cnt == AW'(DEPTH - 1));
  assign mem.dst_we   = wr_valid;
  assign mem.dst_din  = wr_data;
  assign mem.dst_addr = wr_valid ? ~wr_cnt : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      done         <= 1'b0;
      busy         <= 1'b0;
      mem.src_en   <= 1'b0;
      mem.src_addr <= '0;
      wr_cnt       <= '0;
    end else begin
      if (wr_valid) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state        <= RUN;
            busy         <= 1'b1;
            mem.src_en   <= 1'b1;
            mem.src_addr <= '0;
            wr_cnt       <= '0;
          end
        end
        RUN: begin
          // hold the final address rather than wrapping; src_en drops with it
          if (mem.src_addr == AW'(DEPTH - 1)) begin
            state      <= DRAIN;
            mem.src_en <= 1'b0;
          end else begin
            mem.src_addr <= mem.src_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (last_wr) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REV_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (wr_valid) begin
      checksum <= checksum + wr_data;
    end
  end
`endif

endmodule

// File: tb/tb_bram_reverse_core.sv
// tb/tb_bram_reverse_core.sv - directed self-checking bench for bram_reverse_core (RD_LAT 1 and 2)
module tb_bram_reverse_core;
  import rev_pkg::*;

  localparam int DEPTH = 2048;
  localparam int WIDTH = 32;
  localparam int AW    = 11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  logic done1, busy1, done2, busy2;

  always #5 clk = ~clk;

  bram_reverse_core_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) m1 ();
  bram_reverse_core_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) m2 ();

`ifdef REV_CHECKSUM_EN
  logic [WIDTH-1:0] csum1, csum2;
`endif

  bram_reverse_core #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LAT(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .done(done1), .busy(busy1), .mem(m1)
`ifdef REV_CHECKSUM_EN
    , .checksum(csum1)
`endif
  );

  bram_reverse_core #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LAT(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .done(done2), .busy(busy2), .mem(m2)
`ifdef REV_CHECKSUM_EN
    , .checksum(csum2)
`endif
  );

  logic [WIDTH-1:0] src_mem [DEPTH];
  logic [WIDTH-1:0] dst1 [DEPTH];
  logic [WIDTH-1:0] dst2 [DEPTH];
  logic [WIDTH-1:0] dout1 = '0;
  logic [WIDTH-1:0] p2 = '0;
  logic [WIDTH-1:0] dout2 = '0;

  // BRAM models: one and two cycle read latency
  always @(posedge clk) begin
    if (m1.src_en) dout1 <= src_mem[m1.src_addr];
    if (m1.dst_we) dst1[m1.dst_addr] <= m1.dst_din;
  end

  always @(posedge clk) begin
    if (m2.src_en) p2 <= src_mem[m2.src_addr];
    dout2 <= p2;
    if (m2.dst_we) dst2[m2.dst_addr] <= m2.dst_din;
  end

  assign m1.src_dout = dout1;
  assign m2.src_dout = dout2;

  logic          sel = 1'b0;
  logic          en_s, we_s, done_s;
  logic [AW-1:0] addr_s;
  assign en_s   = sel ? m2.src_en   : m1.src_en;
  assign we_s   = sel ? m2.dst_we   : m1.dst_we;
  assign done_s = sel ? done2       : done1;
  assign addr_s = sel ? m2.dst_addr : m1.dst_addr;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_u1_reset(input string tag);
    check({tag, "_done"},     32'(done1),       0);
    check({tag, "_busy"},     32'(busy1),       0);
    check({tag, "_src_en"},   32'(m1.src_en),   0);
    check({tag, "_src_addr"}, 32'(m1.src_addr), 0);
    check({tag, "_dst_we"},   32'(m1.dst_we),   0);
    check({tag, "_dst_addr"}, 32'(m1.dst_addr), 0);
    check({tag, "_dst_din"},  32'(m1.dst_din),  0);
  endtask

  // start sampled at edge 0; cycle n is observed on the negedge after edge n-1
  task automatic run_copy(input bit s, input bit pulse,
                          output int first_rd, output int last_wr, output int done_at,
                          output int nrd, output int nwr, output int ndone, output int last_addr);
    first_rd = -1; last_wr = -1; done_at = -1; nrd = 0; nwr = 0; ndone = 0; last_addr = -1;
    sel = s;
    @(negedge clk);
    if (s) start2 = 1'b1; else start1 = 1'b1;
    for (int n = 1; n <= 2060; n++) begin
      @(negedge clk);
      if (pulse && n == 1) begin
        start1 = 1'b0;
        start2 = 1'b0;
      end
      if (en_s) begin
        nrd++;
        if (first_rd < 0) first_rd = n;
      end
      if (we_s) begin
        nwr++;
        last_wr = n;
        last_addr = int'(addr_s);
      end
      if (done_s) begin
        ndone++;
        if (done_at < 0) done_at = n;
      end
    end
  endtask

  function automatic int count_dst_errs(input bit s);
    int errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (s) begin
        if (dst2[i] !== 32'(DEPTH - 1 - i)) errs++;
      end else begin
        if (dst1[i] !== 32'(DEPTH - 1 - i)) errs++;
      end
    end
    return errs;
  endfunction

  int first_rd, last_wr, done_at, nrd, nwr, ndone, last_addr, wcount;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      src_mem[i] = 32'(i);
      dst1[i] = 32'hDEADBEEF;
      dst2[i] = 32'hDEADBEEF;
    end
    repeat (3) @(negedge clk);
    check_u1_reset("rst");
    reset = 1'b0;
    @(negedge clk);

    // RD_LAT=1, start held high through DONE
    run_copy(1'b0, 1'b0, first_rd, last_wr, done_at, nrd, nwr, ndone, last_addr);
    check("l1_first_rd",  32'(first_rd),  1);
    check("l1_last_wr",   32'(last_wr),   2049);
    check("l1_done_at",   32'(done_at),   2050);
    check("l1_nrd",       32'(nrd),       2048);
    check("l1_nwr",       32'(nwr),       2048);
    check("l1_last_addr", 32'(last_addr), 0);
    check("l1_dst_errs",  32'(count_dst_errs(1'b0)), 0);
    check("l1_dst0",      dst1[0],    2047);
    check("l1_dst2047",   dst1[2047], 0);
    check("l1_dst1000",   dst1[1000], 1047);
`ifdef REV_CHECKSUM_EN
    check("l1_checksum",  csum1, 32'h001FFC00);
`endif

    repeat (5) @(negedge clk);
    check("hold_done",   32'(done1),     1);
    check("hold_busy",   32'(busy1),     0);
    check("hold_src_en", 32'(m1.src_en), 0);
    start1 = 1'b0;
    @(negedge clk);
    check("drop_done", 32'(done1), 0);
    repeat (5) @(negedge clk);
    check("drop_busy",   32'(busy1),     0);
    check("drop_src_en", 32'(m1.src_en), 0);

    // RD_LAT=2, start pulsed for one cycle
    run_copy(1'b1, 1'b1, first_rd, last_wr, done_at, nrd, nwr, ndone, last_addr);
    check("l2_first_rd",  32'(first_rd),  1);
    check("l2_last_wr",   32'(last_wr),   2050);
    check("l2_done_at",   32'(done_at),   2051);
    check("l2_nrd",       32'(nrd),       2048);
    check("l2_nwr",       32'(nwr),       2048);
    check("l2_ndone",     32'(ndone),     1);
    check("l2_last_addr", 32'(last_addr), 0);
    check("l2_dst_errs",  32'(count_dst_errs(1'b1)), 0);
`ifdef REV_CHECKSUM_EN
    check("l2_checksum",  csum2, 32'h001FFC00);
`endif

    // reset in the middle of a RUN on the RD_LAT=1 core
    for (int i = 0; i < DEPTH; i++) dst1[i] = 32'hDEADBEEF;
    sel = 1'b0;
    @(negedge clk);
    start1 = 1'b1;
    for (int n = 1; n <= 1000; n++) @(negedge clk);
    check("mid_busy", 32'(busy1), 1);
    reset = 1'b1;
    @(negedge clk);
    check_u1_reset("mid_rst");
    reset = 1'b0;
    start1 = 1'b0;
    wcount = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m1.dst_we) wcount++;
    end
    check("post_rst_we", 32'(wcount), 0);

    run_copy(1'b0, 1'b1, first_rd, last_wr, done_at, nrd, nwr, ndone, last_addr);
    check("re_done_at",  32'(done_at), 2050);
    check("re_nrd",      32'(nrd),     2048);
    check("re_ndone",    32'(ndone),   1);
    check("re_dst_errs", 32'(count_dst_errs(1'b0)), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
